// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - SRAM owner arbitrating VGA reads over renderer writes
// Fixed read priority with a starvation guard; each access is a timed SRAM cycle.
module sram_access_arbiter #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_den,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAST_CYC   = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cyc;
  logic [CW-1:0]         w_cyc_nxt;
  logic [SW-1:0]         r_starve;
  logic [SW-1:0]         w_starve_nxt;
  logic                  w_last;
  logic                  w_grant_rd;
  logic                  w_grant_wr;
  logic                  w_rd_capture;

  logic                  r_rd_ack;
  logic                  r_wr_ack;
  logic                  r_rd_pend;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_den;
  logic                  r_oe_n;
  logic                  r_we_n;

  assign w_last       = (r_cyc == LAST_CYC);
  assign w_rd_capture = (r_state == S_READ) && w_last;

  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = r_cyc;
    w_starve_nxt = r_starve;
    w_grant_rd   = 1'b0;
    w_grant_wr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cyc_nxt = '0;
        if (wr_req && (!rd_req || r_starve == STARVE_MAX)) begin
          w_grant_wr  = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (rd_req) begin
          w_grant_rd  = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ, S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cyc_nxt   = '0;
        end else begin
          w_cyc_nxt = r_cyc + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The guard only counts reads that overtook a write actually waiting this cycle.
    if (!wr_req || w_grant_wr) begin
      w_starve_nxt = '0;
    end else if (w_grant_rd && r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cyc    <= w_cyc_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Read data is captured at the end of the last READ cycle and flagged one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ack   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_den      <= 1'b0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      r_rd_ack   <= w_grant_rd;
      r_wr_ack   <= w_grant_wr;
      r_oe_n     <= (w_state_nxt != S_READ);
      r_we_n     <= (w_state_nxt != S_WRITE);
      r_den      <= (w_state_nxt == S_WRITE);
      r_rd_pend  <= w_rd_capture;
      r_rd_valid <= r_rd_pend;
      if (w_grant_rd) begin
        r_addr <= rd_addr;
      end
      if (w_grant_wr) begin
        r_addr <= wr_addr;
        r_dout <= wr_data;
      end
      if (w_rd_capture) begin
        r_rd_data <= sram_din;
      end
    end
  end

  assign rd_ack        = r_rd_ack;
  assign wr_ack        = r_wr_ack;
  assign rd_data       = r_rd_data;
  assign rd_data_valid = r_rd_valid;
  assign sram_address  = r_addr;
  assign sram_dout     = r_dout;
  assign sram_den      = r_den;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - scoreboard bench for sram_access_arbiter
// Main instance uses 2-cycle accesses / limit 8; a second instance uses 1-cycle accesses.
module tb_sram_access_arbiter;

  localparam int AC = 2;
  localparam int SL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [19:0] rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        rd_ack, wr_ack, rd_data_valid;
  logic [31:0] rd_data;
  logic [19:0] sram_address;
  logic [31:0] sram_dout, sram_din;
  logic        sram_den, sram_oe_n, sram_we_n;

  logic        rd1_req, wr1_req;
  logic [19:0] rd1_addr, wr1_addr;
  logic [31:0] wr1_data;
  logic        rd1_ack, wr1_ack, rd1_valid;
  logic [31:0] rd1_data;
  logic [19:0] sram1_address;
  logic [31:0] sram1_dout, sram1_din;
  logic        sram1_den, sram1_oe_n, sram1_we_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_access_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .sram_address(sram_address), .sram_dout(sram_dout), .sram_den(sram_den),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_din(sram_din)
  );

  sram_access_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .ACCESS_CYCLES(1), .STARVE_LIMIT(3)) dut1 (
    .clk(clk), .rst(rst),
    .rd_req(rd1_req), .rd_addr(rd1_addr), .rd_ack(rd1_ack), .rd_data(rd1_data), .rd_data_valid(rd1_valid),
    .wr_req(wr1_req), .wr_addr(wr1_addr), .wr_data(wr1_data), .wr_ack(wr1_ack),
    .sram_address(sram1_address), .sram_dout(sram1_dout), .sram_den(sram1_den),
    .sram_oe_n(sram1_oe_n), .sram_we_n(sram1_we_n), .sram_din(sram1_din)
  );

  function automatic logic [31:0] def_word(input logic [3:0] a);
    return (a == 4'h3) ? 32'hDEADBEEF : (32'h13579BD0 + {28'h0, a});
  endfunction

  // Behavioural SRAM: 16 words, unwritten words hold def_word.
  bit [31:0] mem [16];
  bit [15:0] mem_wr;
  assign sram_din  = sram_oe_n ? 32'h0 : (mem_wr[sram_address[3:0]] ? mem[sram_address[3:0]] : def_word(sram_address[3:0]));
  assign sram1_din = sram1_oe_n ? 32'h0 : ({12'h0, sram1_address} ^ 32'hA5A50000);
  always @(posedge clk) begin
    if (!sram_we_n && sram_den) begin
      mem[sram_address[3:0]]    <= sram_dout;
      mem_wr[sram_address[3:0]] <= 1'b1;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: reference memory, arbitration rule and read-return queue.
  bit [31:0]   ref_mem [16];
  bit [15:0]   ref_wr;
  logic [31:0] exp_d [$];
  int          exp_c [$];
  int          ncyc = 0, last_ack = -100, reads_since = 0, n_valid = 0;
  logic        p_rd = 1'b0, p_wr = 1'b0;
  logic [19:0] p_rd_addr = '0, p_wr_addr = '0;
  logic [31:0] p_wr_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_d.delete();
      exp_c.delete();
      reads_since = 0;
      last_ack    = -100;
    end else begin
      if (rd_ack || wr_ack || p_rd || p_wr) begin
        bit want_wr, idle;
        want_wr = p_wr && (!p_rd || reads_since == SL);
        idle    = (ncyc - last_ack) >= AC + 1;
        chk(rd_ack == (idle && p_rd && !want_wr) && wr_ack == (idle && want_wr), "grant",
            {rd_ack, wr_ack}, {idle && p_rd && !want_wr, idle && want_wr});
      end
      if (rd_ack) begin
        exp_d.push_back(ref_wr[p_rd_addr[3:0]] ? ref_mem[p_rd_addr[3:0]] : def_word(p_rd_addr[3:0]));
        exp_c.push_back(ncyc + AC + 1);
      end
      if (wr_ack) begin
        ref_mem[p_wr_addr[3:0]] = p_wr_data;
        ref_wr[p_wr_addr[3:0]]  = 1'b1;
      end
      if (rd_ack || wr_ack) last_ack = ncyc;
      if (!p_wr || wr_ack) reads_since = 0;
      else if (rd_ack && reads_since < SL) reads_since++;
      if (rd_data_valid) begin
        n_valid++;
        if (exp_d.size() == 0) begin
          chk(1'b0, "unexpected_rd_valid", rd_data, 0);
        end else begin
          chk(rd_data == exp_d[0], "rd_data", rd_data, exp_d[0]);
          chk(ncyc == exp_c[0], "rd_latency", ncyc, exp_c[0]);
          void'(exp_d.pop_front());
          void'(exp_c.pop_front());
        end
      end
      chk(!(!sram_oe_n && !sram_we_n) && (sram_den == !sram_we_n), "bus_proto",
          {sram_oe_n, sram_we_n, sram_den}, 3'b110);
    end
    p_rd = rd_req; p_wr = wr_req;
    p_rd_addr = rd_addr; p_wr_addr = wr_addr; p_wr_data = wr_data;
    ncyc++;
  end

  task automatic next_ack(output bit got_rd, output bit got_wr, output int at);
    got_rd = 1'b0; got_wr = 1'b0; at = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (rd_ack || wr_ack) begin
        got_rd = rd_ack; got_wr = wr_ack; at = cyc;
        return;
      end
    end
    chk(1'b0, "ack_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got 1 required 0");
    $fatal(1, "timeout");
  end

  initial begin
    bit gr, gw;
    int at, last, cnt, nv;
    int acks [$];
    int vals [$];
    rst = 1'b1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    rd1_req = 0; wr1_req = 0; rd1_addr = '0; wr1_addr = '0; wr1_data = '0;
    repeat (2) @(posedge clk); #1;
    chk({sram_oe_n, sram_we_n, sram_den, rd_ack, wr_ack, rd_data_valid} == 6'b110000, "reset_ctrl",
        {sram_oe_n, sram_we_n, sram_den, rd_ack, wr_ack, rd_data_valid}, 6'b110000);
    chk(sram_address == 0 && sram_dout == 0 && rd_data == 0, "reset_data", {sram_address, sram_dout}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single read
    rd_req = 1; rd_addr = 20'h00123;
    @(posedge clk); #1;
    chk(rd_ack == 1, "t1_ack", rd_ack, 1);
    chk(!sram_oe_n && sram_address == 20'h00123, "t1_oe0", {sram_oe_n, sram_address}, 20'h00123);
    rd_req = 0;
    @(posedge clk); #1;
    chk(!sram_oe_n && sram_address == 20'h00123, "t1_oe1", {sram_oe_n, sram_address}, 20'h00123);
    @(posedge clk); #1;
    chk(sram_oe_n == 1 && rd_data_valid == 0, "t1_idle", {sram_oe_n, rd_data_valid}, 2'b10);
    @(posedge clk); #1;
    chk(rd_data_valid && rd_data == 32'hDEADBEEF, "t1_data", {rd_data_valid, rd_data}, {1'b1, 32'hDEADBEEF});

    // Single write
    repeat (2) @(posedge clk); #1;
    wr_req = 1; wr_addr = 20'h00040; wr_data = 32'h12345678;
    @(posedge clk); #1;
    chk(wr_ack == 1, "t2_ack", wr_ack, 1);
    wr_req = 0;
    for (int k = 0; k < 2; k++) begin
      chk({sram_den, sram_we_n, sram_oe_n} == 3'b101 && sram_address == 20'h00040 && sram_dout == 32'h12345678,
          "t2_bus", {sram_den, sram_we_n, sram_oe_n, sram_address, sram_dout}, {3'b101, 20'h00040, 32'h12345678});
      @(posedge clk); #1;
    end
    chk({sram_den, sram_we_n, sram_oe_n} == 3'b011, "t2_idle", {sram_den, sram_we_n, sram_oe_n}, 3'b011);

    // Contention: 8 reads then 1 write, one IDLE between grants
    repeat (2) @(posedge clk); #1;
    rd_addr = 20'h2; wr_addr = 20'h9; wr_data = 32'hCAFE0001; rd_req = 1; wr_req = 1;
    last = 0;
    for (int g = 0; g < 18; g++) begin
      next_ack(gr, gw, at);
      chk(gw == (g % 9 == 8) && gr == !(g % 9 == 8), "t3_kind", {gr, gw}, g);
      if (g > 0) chk(at - last == AC + 1, "t3_gap", at - last, AC + 1);
      last = at;
    end
    rd_req = 0; wr_req = 0;

    // Simultaneous with starve_cnt=0, then starve clear on wr_req drop
    repeat (4) @(posedge clk); #1;
    rd_addr = 20'h5; wr_addr = 20'h5; wr_data = 32'h0BADF00D; rd_req = 1; wr_req = 1;
    next_ack(gr, gw, at);
    chk(gr && !gw, "t4_read_first", {gr, gw}, 2'b10);
    rd_req = 0;
    next_ack(gr, gw, last);
    chk(gw && last - at == AC + 1, "t4_write_next", {gw, last - at}, {1'b1, AC + 1});
    wr_req = 0;
    @(posedge clk); #1;
    rd_req = 1; wr_req = 1; rd_addr = 20'h6; wr_addr = 20'h7; wr_data = 32'h77777777;
    for (int k = 0; k < 4; k++) next_ack(gr, gw, at);
    wr_req = 0;
    repeat (2) @(posedge clk); #1;
    wr_req = 1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      next_ack(gr, gw, at);
      if (gw) break;
      cnt++;
    end
    chk(cnt == SL, "t4_starve_clear", cnt, SL);
    rd_req = 0; wr_req = 0;

    // Reset in first READ cycle
    repeat (4) @(posedge clk); #1;
    rd_req = 1; rd_addr = 20'h7;
    next_ack(gr, gw, at);
    rst = 1; rd_req = 0;
    #1;
    chk({sram_oe_n, sram_we_n, sram_den, rd_ack, wr_ack} == 5'b11000 && sram_address == 0 && sram_dout == 0
        && rd_data == 0, "t5_async_reset", {sram_oe_n, sram_we_n, sram_den, rd_ack, sram_address}, {5'b11000, 20'h0});
    nv = n_valid;
    @(posedge clk); #1;
    rst = 0;
    repeat (8) @(posedge clk); #1;
    chk(n_valid == nv && rd_data_valid == 0, "t5_no_valid", n_valid - nv, 0);

    // Randomised traffic, checked by the monitor
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (rd_ack) begin
        rd_req = ($urandom % 2) == 0; rd_addr = 20'($urandom % 16);
      end else if (!rd_req) begin
        if ($urandom % 3 == 0) begin rd_req = 1; rd_addr = 20'($urandom % 16); end
      end else if ($urandom % 25 == 0) begin
        rd_req = 0;
      end
      if (wr_ack) begin
        wr_req = ($urandom % 3) == 0; wr_addr = 20'($urandom % 16); wr_data = $urandom;
      end else if (!wr_req) begin
        if ($urandom % 4 == 0) begin wr_req = 1; wr_addr = 20'($urandom % 16); wr_data = $urandom; end
      end else if ($urandom % 25 == 0) begin
        wr_req = 0;
      end
    end
    rd_req = 0; wr_req = 0;
    repeat (8) @(posedge clk); #1;
    chk(exp_d.size() == 0, "drain", exp_d.size(), 0);

    // ACCESS_CYCLES=1 instance: held read
    rd1_req = 1; rd1_addr = 20'h55;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (rd1_ack) acks.push_back(cyc);
      if (rd1_valid) begin
        vals.push_back(cyc);
        chk(rd1_data == 32'hA5A50055, "t6_data", rd1_data, 32'hA5A50055);
      end
    end
    rd1_req = 0;
    chk(acks.size() >= 6 && vals.size() >= 5, "t6_counts", {acks.size(), vals.size()}, {32'd7, 32'd6});
    for (int i = 1; i < acks.size(); i++) chk(acks[i] - acks[i-1] == 2, "t6_ack_gap", acks[i] - acks[i-1], 2);
    for (int i = 0; i < vals.size() && i < acks.size(); i++)
      chk(vals[i] - acks[i] == 2, "t6_valid_lat", vals[i] - acks[i], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
